// File: rtl/sd_reg_pkg.sv
// Shared types, register map and register-type lookup for the SD host register bank.
package sd_reg_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'b00,
    ACC_BYTE = 2'b01,
    ACC_HALF = 2'b10,
    ACC_WORD = 2'b11
  } acc_e;

  typedef enum logic [1:0] {
    REG_RW  = 2'd0,
    REG_RO  = 2'd1,
    REG_W1C = 2'd2
  } reg_type_e;

  localparam int IDX_ARG   = 0;
  localparam int IDX_CMD   = 1;
  localparam int IDX_BLKSZ = 2;
  localparam int IDX_BLKCN = 3;
  localparam int IDX_RESP0 = 8;
  localparam int IDX_RESP1 = 9;
  localparam int IDX_RESP2 = 10;
  localparam int IDX_RESP3 = 11;
  localparam int IDX_STAT  = 12;
  localparam int IDX_EN    = 13;

  // Status index takes precedence over the RO mask should they overlap.
  function automatic reg_type_e reg_type(input int idx, input logic [63:0] ro_mask,
                                         input int stat_idx);
    if (idx == stat_idx) return REG_W1C;
    if (ro_mask[idx]) return REG_RO;
    return REG_RW;
  endfunction

endpackage

// File: rtl/sd_reg_lane_merge.sv
// Combinational byte-lane decode: lane enables, misalignment flag and the merged write word.
module sd_reg_lane_merge
  import sd_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  acc_e              size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [3:0]        lane_en_o,
  output logic              misalign_o,
  output logic [DATA_W-1:0] merged_o
);

  always_comb begin
    lane_en_o  = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      ACC_BYTE: lane_en_o = 4'b0001 << addr_lo_i;
      ACC_HALF: begin
        lane_en_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      ACC_WORD: begin
        lane_en_o  = 4'b1111;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    merged_o = old_i;
    for (int l = 0; l < 4; l++) begin
      if (lane_en_o[l]) merged_o[l*8 +: 8] = data_i[l*8 +: 8];
    end
  end

endmodule

// File: rtl/sd_reg_bank.sv
// SD host register bank: sized bus accesses with 1-cycle registered ack/err/read data,
// RW/RO/W1C register types, hardware update port and registered interrupt output.
module sd_reg_bank
  import sd_reg_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 8,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = 16'h0F00,
  parameter int                  STAT_IDX = 12,
  parameter int                  EN_IDX   = 13
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wnr,
  input  logic [1:0]                   req,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic                         ack,
  output logic                         err,
  input  logic                         hw_wr,
  input  logic [$clog2(NUM_REGS)-1:0]  hw_idx,
  input  logic [DATA_W-1:0]            hw_data,
  input  logic [DATA_W-1:0]            irq_set,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         irq
);

  localparam int WIDX_W = ADDR_W - 2;
  localparam int HW_W   = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] data_out_q;
  logic              ack_q, err_q, irq_q;

  acc_e              acc;
  logic [WIDX_W-1:0] widx;
  logic              mapped, misalign, acc_err, wr_ok;
  logic [3:0]        lane_en;
  logic [DATA_W-1:0] rd_word, merged, clr_mask;

  assign acc  = acc_e'(req);
  assign widx = address[ADDR_W-1:2];

  always_comb begin
    mapped  = (int'(widx) < NUM_REGS);
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (widx == WIDX_W'(i)) rd_word = regs_q[i];
    end
  end

  sd_reg_lane_merge #(.DATA_W(DATA_W)) u_lane_merge (
    .size_i     (acc),
    .addr_lo_i  (address[1:0]),
    .old_i      (rd_word),
    .data_i     (data_in),
    .lane_en_o  (lane_en),
    .misalign_o (misalign),
    .merged_o   (merged)
  );

  always_comb begin
    acc_err = (acc != ACC_IDLE) && (misalign || !mapped);
    wr_ok   = (acc != ACC_IDLE) && wnr && !misalign && mapped;
    for (int l = 0; l < 4; l++) clr_mask[l*8 +: 8] = data_in[l*8 +: 8] & {8{lane_en[l]}};
  end

  // Status applies clear before set, so a same-cycle set always survives.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      case (reg_type(i, 64'(RO_MASK), STAT_IDX))
        REG_RW:  if (wr_ok && widx == WIDX_W'(i)) regs_d[i] = merged;
        REG_RO:  if (hw_wr && hw_idx == HW_W'(i)) regs_d[i] = hw_data;
        REG_W1C: regs_d[i] = (regs_q[i] & ~((wr_ok && widx == WIDX_W'(i)) ? clr_mask : '0))
                             | irq_set;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      data_out_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ack_q  <= (acc != ACC_IDLE);
      err_q  <= acc_err;
      if (acc != ACC_IDLE && !wnr) data_out_q <= acc_err ? '0 : rd_word;
      irq_q  <= |(regs_q[STAT_IDX] & regs_q[EN_IDX]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign data_out = data_out_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sd_reg_bank.sv
// Directed bench for sd_reg_bank: hand-computed expectations, checked one cycle after each request.
module tb_sd_reg_bank;

  localparam logic [1:0] BYTE = 2'b01, HALF = 2'b10, WORD = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         wnr;
  logic [1:0]   req;
  logic [7:0]   address;
  logic [31:0]  data_in;
  logic [31:0]  data_out;
  logic         ack, err;
  logic         hw_wr;
  logic [3:0]   hw_idx;
  logic [31:0]  hw_data;
  logic [31:0]  irq_set;
  logic [511:0] regs_out;
  logic         irq;

  int n_vec = 0;
  int n_bad = 0;

  sd_reg_bank dut (
    .clk(clk), .reset(reset), .wnr(wnr), .req(req), .address(address),
    .data_in(data_in), .data_out(data_out), .ack(ack), .err(err),
    .hw_wr(hw_wr), .hw_idx(hw_idx), .hw_data(hw_data), .irq_set(irq_set),
    .regs_out(regs_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regs_out[i*32 +: 32];
  endfunction

  // Called right after a negedge; presents one request for one cycle, returns at the next negedge.
  task automatic access(input logic w, input logic [1:0] r, input logic [7:0] a,
                        input logic [31:0] d);
    wnr = w; req = r; address = a; data_in = d;
    @(negedge clk);
    wnr = 1'b0; req = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_resp(input string tag, input logic e_err);
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e_err});
  endtask

  initial begin
    reset = 1'b1; wnr = 1'b0; req = 2'b00; address = '0; data_in = '0;
    hw_wr = 1'b0; hw_idx = '0; hw_data = '0; irq_set = '0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // 1: reset state, word write/read
    chk("rst_regs", {31'b0, |regs_out}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_dout", data_out, 32'd0);
    access(1'b1, WORD, 8'h00, 32'hDEADBEEF);
    chk_resp("w0", 1'b0);
    access(1'b0, WORD, 8'h00, 32'h0);
    chk_resp("r0", 1'b0);
    chk("r0_data", data_out, 32'hDEADBEEF);
    idle(1);
    chk("idle_ack", {31'b0, ack}, 32'd0);
    chk("idle_dout_hold", data_out, 32'hDEADBEEF);

    // 2: byte merge, misaligned half
    access(1'b1, WORD, 8'h04, 32'h11223344);
    access(1'b1, BYTE, 8'h05, 32'h0000AA00);
    chk_resp("wb5", 1'b0);
    chk("reg1_byte", reg_at(1), 32'h1122AA44);
    access(1'b1, HALF, 8'h07, 32'hFFFF0000);
    chk_resp("wh7", 1'b1);
    chk("reg1_keep", reg_at(1), 32'h1122AA44);
    access(1'b1, HALF, 8'h06, 32'hBEEF0000);
    chk_resp("wh6", 1'b0);
    chk("reg1_half", reg_at(1), 32'hBEEFAA44);
    access(1'b0, WORD, 8'h02, 32'h0);
    chk_resp("rw2_mis", 1'b1);
    chk("rw2_data", data_out, 32'h0);

    // 3: unmapped
    access(1'b0, WORD, 8'hFC, 32'h0);
    chk_resp("rFC", 1'b1);
    chk("rFC_data", data_out, 32'h0);
    access(1'b1, WORD, 8'hFC, 32'h12345678);
    chk_resp("wFC", 1'b1);
    access(1'b1, WORD, 8'h40, 32'h87654321);
    chk_resp("w40", 1'b1);
    chk("unm_reg0", reg_at(0), 32'hDEADBEEF);
    chk("unm_reg1", reg_at(1), 32'hBEEFAA44);
    chk("unm_reg15", reg_at(15), 32'h0);

    // 4: RO registers and hw port
    hw_wr = 1'b1; hw_idx = 4'd8; hw_data = 32'h5A5A0001;
    idle(1);
    hw_wr = 1'b0;
    access(1'b0, WORD, 8'h20, 32'h0);
    chk_resp("r20", 1'b0);
    chk("r20_data", data_out, 32'h5A5A0001);
    access(1'b1, WORD, 8'h20, 32'h0);
    chk_resp("w20_ro", 1'b0);
    chk("reg8_kept", reg_at(8), 32'h5A5A0001);
    hw_wr = 1'b1; hw_idx = 4'd0; hw_data = 32'h0BADF00D;
    idle(1);
    hw_wr = 1'b0;
    chk("hw_rw_ign", reg_at(0), 32'hDEADBEEF);
    hw_wr = 1'b1; hw_idx = 4'd9; hw_data = 32'h00000001;
    idle(1);
    hw_idx = 4'd9; hw_data = 32'h00000002;
    access(1'b0, WORD, 8'h24, 32'h0);
    hw_wr = 1'b0;
    chk("r24_old", data_out, 32'h00000001);
    chk("reg9_new", reg_at(9), 32'h00000002);

    // 5: status / enable / irq
    access(1'b1, WORD, 8'h34, 32'h00000001);
    irq_set = 32'h1;
    idle(1);
    irq_set = 32'h0;
    chk("stat_set", reg_at(12), 32'h1);
    chk("irq_lag", {31'b0, irq}, 32'd0);
    idle(1);
    chk("irq_rise", {31'b0, irq}, 32'd1);
    access(1'b0, WORD, 8'h30, 32'h0);
    chk("stat_read", data_out, 32'h1);
    access(1'b1, WORD, 8'h30, 32'h1);
    chk_resp("w1c", 1'b0);
    chk("stat_clr", reg_at(12), 32'h0);
    idle(1);
    chk("irq_fall", {31'b0, irq}, 32'd0);
    irq_set = 32'h1;
    access(1'b1, WORD, 8'h30, 32'h1);
    irq_set = 32'h0;
    chk("set_wins", reg_at(12), 32'h1);
    irq_set = 32'h300;
    idle(1);
    irq_set = 32'h0;
    access(1'b1, BYTE, 8'h30, 32'h00000100);
    chk("w1c_lane0", reg_at(12), 32'h301);
    access(1'b1, BYTE, 8'h31, 32'h00000100);
    chk("w1c_lane1", reg_at(12), 32'h201);

    // 6: back-to-back, then reset mid-stream
    access(1'b1, WORD, 8'h08, 32'hCAFEF00D);
    chk_resp("b2b_w", 1'b0);
    access(1'b0, WORD, 8'h08, 32'h0);
    chk_resp("b2b_r", 1'b0);
    chk("b2b_rdata", data_out, 32'hCAFEF00D);
    access(1'b1, WORD, 8'h0C, 32'h12345678);
    chk_resp("b2b_w2", 1'b0);
    chk("b2b_reg3", reg_at(3), 32'h12345678);
    reset = 1'b1;
    access(1'b1, WORD, 8'h10, 32'hFFFFFFFF);
    reset = 1'b0;
    chk("mid_rst_ack", {31'b0, ack}, 32'd0);
    chk("mid_rst_regs", {31'b0, |regs_out}, 32'd0);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    chk("mid_rst_dout", data_out, 32'd0);
    idle(1);
    chk("post_rst_ack", {31'b0, ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
